// File: rtl/brisc_pkg.sv
// Shared opcode constants, encoder request kinds, FSM states and the immediate range helper.
// No logic of its own; imported by the encoder and its field packer.
package brisc_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_END    = 7'b0001011;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ENC_ADD, ENC_SUB, ENC_MUL, ENC_OR, ENC_AND, ENC_ADDI, ENC_ORI, ENC_ANDI,
    ENC_LB, ENC_LW, ENC_SB, ENC_SW, ENC_BEQ, ENC_JAL, ENC_AUIPC, ENC_END
  } enc_kind_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} enc_state_e;

  // True when v is representable as a signed (msb+1)-bit value: bits [31:msb] all equal.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32 field packer: builds the raw instruction word and flags whether
// the immediate fits its format. Zero latency, no handshake.
module instr_field_pack
  import brisc_pkg::*;
(
  input  enc_kind_e   kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  always_comb begin
    instr = 32'h0;
    legal = 1'b1;
    case (kind)
      ENC_ADD: instr = {7'b0000000, rs2, rs1, 3'b000, rd, OPCODE_OP};
      ENC_SUB: instr = {7'b0100000, rs2, rs1, 3'b000, rd, OPCODE_OP};
      ENC_MUL: instr = {7'b0000001, rs2, rs1, 3'b000, rd, OPCODE_OP};
      ENC_OR:  instr = {7'b0000000, rs2, rs1, 3'b110, rd, OPCODE_OP};
      ENC_AND: instr = {7'b0000000, rs2, rs1, 3'b111, rd, OPCODE_OP};
      ENC_ADDI: begin
        legal = fits_signed(imm, 11);
        instr = {imm[11:0], rs1, 3'b000, rd, OPCODE_OP_IMM};
      end
      ENC_ORI: begin
        legal = fits_signed(imm, 11);
        instr = {imm[11:0], rs1, 3'b110, rd, OPCODE_OP_IMM};
      end
      ENC_ANDI: begin
        legal = fits_signed(imm, 11);
        instr = {imm[11:0], rs1, 3'b111, rd, OPCODE_OP_IMM};
      end
      ENC_LB: begin
        legal = fits_signed(imm, 11);
        instr = {imm[11:0], rs1, 3'b000, rd, OPCODE_LOAD};
      end
      ENC_LW: begin
        legal = fits_signed(imm, 11);
        instr = {imm[11:0], rs1, 3'b010, rd, OPCODE_LOAD};
      end
      ENC_SB: begin
        legal = fits_signed(imm, 11);
        instr = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], OPCODE_STORE};
      end
      ENC_SW: begin
        legal = fits_signed(imm, 11);
        instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPCODE_STORE};
      end
      ENC_BEQ: begin
        legal = fits_signed(imm, 12) & ~imm[0];
        instr = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPCODE_BRANCH};
      end
      ENC_JAL: begin
        legal = fits_signed(imm, 20) & ~imm[0];
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPCODE_JAL};
      end
      ENC_AUIPC: begin
        legal = (imm[11:0] == 12'h000);
        instr = {imm[31:12], rd, OPCODE_AUIPC};
      end
      ENC_END: instr = {25'h0, OPCODE_END};
      default: instr = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Session encoder: requests become addressed RV32 words one cycle after acceptance through a
// single-entry output register; in_ready drops while that entry is stalled, full rate otherwise.
module instr_encoder
  import brisc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  enc_kind_e             in_kind,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_err,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            err_cnt
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

  enc_state_e            state;
  logic                  end_seen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           word;
  logic                  legal;
  logic                  accept;
  logic                  pop;

  instr_field_pack u_pack (
    .kind  (in_kind),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .instr (word),
    .legal (legal)
  );

  assign in_ready = (state == ST_RUN) & ~end_seen & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      end_seen  <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      err_cnt   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            addr     <= base_addr;
            err_cnt  <= 8'h00;
            end_seen <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_instr <= legal ? word : INSTR_NOP;
            out_err   <= ~legal;
            out_addr  <= addr;
            addr      <= addr + ADDR_STEP;
            if (!legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (in_kind == ENC_END) end_seen <= 1'b1;
          end else if (pop) begin
            out_valid <= 1'b0;
            // Once END is latched no other word can enter, so this pop is the END word.
            if (end_seen) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a queue scoreboard and an independent output monitor.
module tb_instr_encoder;
  import brisc_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  localparam logic [31:0] END_WORD = 32'h0000_000B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  enc_kind_e   in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a word is transferred at the posedge following a negedge where valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%08h, expected none", out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_addr", out_addr, e.addr);
        chk("out_err", {31'h0, out_err}, {31'h0, e.err});
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_addr  = b;
  endtask

  task automatic send(input enc_kind_e k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_i, input logic exp_e, output int waited);
    bit got;
    got      = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_kind  = k;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    while (!got && waited < 100) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{instr: exp_i, addr: exp_addr, err: exp_e});
        exp_addr = exp_addr + 32'd4;
        got = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_full_rate(input enc_kind_e k, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [31:0] exp_i, input logic exp_e);
    int w;
    send(k, rd, rs1, rs2, imm, exp_i, exp_e, w);
    chk("stream_wait_cycles", w, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    int w;
    logic [31:0] stall_addr;
    rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0; in_kind = ENC_ADD;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0; out_ready = 1'b0;
    exp_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Session 1: single ADD then END.
    out_ready = 1'b1;
    do_start(32'h100);
    chk("run_busy", {31'h0, busy}, 32'h1);
    chk("run_in_ready", {31'h0, in_ready}, 32'h1);
    send(ENC_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0, w);
    send(ENC_END, 5'd0, 5'd0, 5'd0, 32'h0, END_WORD, 1'b0, w);
    drain();
    chk("end_done", {31'h0, done}, 32'h1);
    chk("end_busy", {31'h0, busy}, 32'h0);
    chk("end_in_ready", {31'h0, in_ready}, 32'h0);

    // Session 2: immediates, stall, full-rate stream, saturation.
    do_start(32'h100);
    send(ENC_ADDI, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0, w);
    send(ENC_BEQ,  5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463, 1'b0, w);
    send(ENC_JAL,  5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 1'b0, w);
    send(ENC_ADDI, 5'd5, 5'd0, 5'd0, 32'd2048,     INSTR_NOP,    1'b1, w);
    drain();
    chk("err_cnt_one", {24'h0, err_cnt}, 32'h1);

    out_ready = 1'b0;
    send(ENC_SUB, 5'd1, 5'd2, 5'd3, 32'h0, 32'h403100B3, 1'b0, w);
    stall_addr = exp_addr - 32'd4;
    in_valid = 1'b1; in_kind = ENC_MUL; in_rd = 5'd4; in_rs1 = 5'd5; in_rs2 = 5'd6;
    start = 1'b1; base_addr = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_out_instr", out_instr, 32'h403100B3);
      chk("stall_out_addr", out_addr, stall_addr);
    end
    out_ready = 1'b1;
    send_full_rate(ENC_MUL,   5'd4,  5'd5,  5'd6,  32'h0,        32'h02628233, 1'b0);
    send_full_rate(ENC_OR,    5'd7,  5'd8,  5'd9,  32'h0,        32'h009463B3, 1'b0);
    send_full_rate(ENC_AND,   5'd1,  5'd1,  5'd1,  32'h0,        32'h0010F0B3, 1'b0);
    send_full_rate(ENC_ORI,   5'd2,  5'd3,  5'd0,  32'h7FF,      32'h7FF1E113, 1'b0);
    send_full_rate(ENC_ANDI,  5'd2,  5'd2,  5'd0,  32'hFFFF_F800, 32'h80017113, 1'b0);
    send_full_rate(ENC_LB,    5'd10, 5'd11, 5'd0,  32'd4,        32'h00458503, 1'b0);
    send_full_rate(ENC_LW,    5'd10, 5'd2,  5'd0,  32'hFFFF_FFFC, 32'hFFC12503, 1'b0);
    send_full_rate(ENC_SW,    5'd0,  5'd2,  5'd10, 32'd8,        32'h00A12423, 1'b0);
    send_full_rate(ENC_SB,    5'd0,  5'd1,  5'd5,  32'hFFFF_FFFF, 32'hFE508FA3, 1'b0);
    send_full_rate(ENC_AUIPC, 5'd5,  5'd0,  5'd0,  32'h1234_5000, 32'h12345297, 1'b0);
    send_full_rate(ENC_AUIPC, 5'd5,  5'd0,  5'd0,  32'h1234_5001, INSTR_NOP,    1'b1);
    send_full_rate(ENC_BEQ,   5'd0,  5'd1,  5'd2,  32'd3,        INSTR_NOP,    1'b1);
    send_full_rate(ENC_BEQ,   5'd0,  5'd1,  5'd2,  32'hFFFF_F000, 32'h80208063, 1'b0);
    send_full_rate(ENC_JAL,   5'd1,  5'd0,  5'd0,  32'h0010_0000, INSTR_NOP,    1'b1);
    drain();
    chk("err_cnt_four", {24'h0, err_cnt}, 32'h4);
    for (int i = 0; i < 255; i++)
      send(ENC_ADDI, 5'd1, 5'd1, 5'd0, 32'h0000_1000, INSTR_NOP, 1'b1, w);
    drain();
    chk("err_cnt_saturated", {24'h0, err_cnt}, 32'hFF);
    send(ENC_END, 5'd0, 5'd0, 5'd0, 32'h0, END_WORD, 1'b0, w);
    drain();
    chk("end2_done", {31'h0, done}, 32'h1);

    // Session 3: address wrap, then reset with a stalled word pending.
    do_start(32'hFFFF_FFFC);
    chk("restart_err_cnt", {24'h0, err_cnt}, 32'h0);
    send(ENC_ADD,  5'd3, 5'd1, 5'd2, 32'h0,    32'h002081B3, 1'b0, w);
    send(ENC_ADDI, 5'd5, 5'd0, 5'd0, 32'd2048, INSTR_NOP,    1'b1, w);
    drain();
    chk("wrap_out_addr", out_addr, 32'h0);
    chk("wrap_err_cnt", {24'h0, err_cnt}, 32'h1);
    out_ready = 1'b0;
    send(ENC_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0, w);
    chk("pre_rst_out_valid", {31'h0, out_valid}, 32'h1);
    chk("pre_rst_pending", sb.size(), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_out_instr", out_instr, 32'h0);
    chk("mid_rst_out_addr", out_addr, 32'h0);
    chk("mid_rst_out_err", {31'h0, out_err}, 32'h0);
    chk("mid_rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'h0, in_ready}, 32'h0);
    chk("idle_out_valid", {31'h0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
